fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage pipelined MIPS core: owns the PC register, the next-PC mux and the IF/ID pipeline register.
- Consumes the hazard unit's control outputs (PCHold, IF_ID_Hold, IF_ID_Stall) and PCSrc from the control path.
- Drives the instruction-ROM address and delivers instruction, PC+4, valid and interrupt tag to ID.
- Latches external interrupt requests and injects them as tagged bubbles.

Parameters:
- RESET_PC, 32'h80000000, PC value after reset (kernel mode, bit 31 = 1).
- ILLOP_PC, 32'h80000004, illegal-op / exception vector.
- XADR_PC, 32'h80000008, interrupt vector.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PCSrc  input  3  next-PC select: 0 PC+4, 1 BranchTarget, 2 JumpTarget, 3 JrTarget, 4 ILLOP_PC, 5 XADR_PC, 6/7 treated as 0.
- PCHold  input  1  keep PC unchanged this cycle.
- IF_ID_Hold  input  1  keep IF/ID register contents.
- IF_ID_Stall  input  1  load bubble into IF/ID (flush).
- BranchTarget  input  32  resolved branch target.
- JumpTarget  input  26  J/JAL instr_index field.
- JrTarget  input  32  register-sourced target (JR/JALR).
- IRQ  input  1  level-sensitive external interrupt.
- InstAddr  output  32  instruction-ROM address, equal to PC.
- Inst  input  32  ROM data, combinational from InstAddr.
- ID_Inst  output  32  instruction in ID.
- ID_PCPlus4  output  32  PC+4 of instruction in ID.
- ID_Valid  output  1  1 = real instruction, 0 = bubble.
- ID_Irq  output  1  1 = interrupt bubble; ID must issue PCSrc=5.

Behaviour:
- Reset: PC=RESET_PC; ID_Inst=0; ID_PCPlus4=0; ID_Valid=0; ID_Irq=0; IrqPending=0.
- PCPlus4 = {PC[31], PC[30:0]+4}. Low 31 bits wrap modulo 2^31; bit 31 (kernel bit) is preserved.
- Next PC by PCSrc:
  - 0: PCPlus4
  - 1: BranchTarget
  - 2: {PC[31], ID_PCPlus4[30:28], JumpTarget, 2'b00}
  - 3: JrTarget verbatim; may clear the kernel bit.
  - 4: ILLOP_PC
  - 5: XADR_PC
- PC update: PCHold=1 → PC unchanged; otherwise PC ← next PC. Latency: target visible on InstAddr one cycle after PCSrc is presented.
- IF/ID update priority: reset > IF_ID_Stall > IF_ID_Hold > interrupt injection > normal load.
  - Stall: Inst=0, Valid=0, Irq=0; PCPlus4 ← PCPlus4.
  - Hold: all IF/ID fields unchanged.
  - Stall+Hold together: Stall wins.
- Normal load: ID_Inst=Inst, ID_PCPlus4=PCPlus4, ID_Valid=1, ID_Irq=0.
- Interrupt FSM, states IDLE / PENDING:
  - IDLE→PENDING when IRQ=1 and PC[31]=0.
  - In PENDING, on the first cycle with no Stall, no Hold, PCSrc=0 and PC[31]=0: load ID_Inst=0, ID_Valid=0, ID_Irq=1, ID_PCPlus4=PCPlus4 (EPC source), then go to IDLE.
  - PCSrc≠0 in that cycle defers injection; the redirect target is fetched first.
  - PC[31]=1 while PENDING: remain PENDING, masked.
  - IRQ deasserting while PENDING does not cancel it.
  - PCHold=1 does not block injection; PC is still held.
- Reset mid-operation: all state returns to reset values on the next edge, IrqPending included.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds outputs StallCount[31:0] (cycles with PCHold=1), FlushCount[31:0] (cycles with IF_ID_Stall=1) and IrqCount[15:0] (injections). All counters reset to 0 and wrap at all-ones.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then 3 cycles of PCSrc=0 with ROM returning A,B,C → InstAddr 80000000, 80000004, 80000008; ID_Valid=0 then 1; ID_PCPlus4=80000004 with ID_Inst=A.
- Load-use: PCHold=IF_ID_Hold=1 for 1 cycle with PC=00000010 → PC stays 00000010; ID_Inst/ID_PCPlus4 unchanged; following cycle resumes at 00000014.
- Branch: PCSrc=1, BranchTarget=00000100, IF_ID_Stall=1 → next InstAddr=00000100, ID_Valid=0, ID_Inst=0.
- JR from kernel: PC=80000020, PCSrc=3, JrTarget=00000040 → InstAddr=00000040; next PCPlus4=00000044, bit 31 clear.
- IRQ pulsed 1 cycle while PC=00000030, PCSrc=0 → ID_Irq=1, ID_Valid=0, ID_PCPlus4=00000034. IRQ at PC=80000030 → no injection until a user-mode PC is reached.
- Stall and Hold asserted together → bubble loaded; Wrap test: PC=7FFFFFFC with PCSrc=0 → PC=00000000.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC mux, IF/ID register and interrupt-bubble injection.
// Optional performance counters are enabled with `define FETCH_STATS_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter logic [31:0] ILLOP_PC = 32'h80000004,
    parameter logic [31:0] XADR_PC  = 32'h80000008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        PCHold,
    input  logic        IF_ID_Hold,
    input  logic        IF_ID_Stall,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] JrTarget,
    input  logic        IRQ,
    output logic [31:0] InstAddr,
    input  logic [31:0] Inst,
    output logic [31:0] ID_Inst,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_Valid,
    output logic        ID_Irq
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount,
    output logic [15:0] IrqCount
`endif
);

    typedef enum logic {IDLE, PENDING} irq_state_t;

    irq_state_t  irq_state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        inject;

    assign InstAddr = pc;
    // Kernel bit is sticky across sequential fetch; only the low 31 bits count.
    assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            3'd1:    next_pc = BranchTarget;
            3'd2:    next_pc = {pc[31], ID_PCPlus4[30:28], JumpTarget, 2'b00};
            3'd3:    next_pc = JrTarget;
            3'd4:    next_pc = ILLOP_PC;
            3'd5:    next_pc = XADR_PC;
            default: next_pc = pc_plus4;
        endcase
    end

    // Inject only on a quiet user-mode cycle so any pending redirect is fetched first.
    assign inject = (irq_state == PENDING) && !IF_ID_Stall && !IF_ID_Hold &&
                    (PCSrc == 3'd0) && !pc[31];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            ID_Inst    <= 32'd0;
            ID_PCPlus4 <= 32'd0;
            ID_Valid   <= 1'b0;
            ID_Irq     <= 1'b0;
            irq_state  <= IDLE;
        end else begin
            if (!PCHold)
                pc <= next_pc;

            if (IF_ID_Stall) begin
                ID_Inst    <= 32'd0;
                ID_PCPlus4 <= pc_plus4;
                ID_Valid   <= 1'b0;
                ID_Irq     <= 1'b0;
            end else if (!IF_ID_Hold) begin
                ID_Inst    <= inject ? 32'd0 : Inst;
                ID_PCPlus4 <= pc_plus4;
                ID_Valid   <= !inject;
                ID_Irq     <= inject;
            end

            case (irq_state)
                IDLE:    if (IRQ && !pc[31]) irq_state <= PENDING;
                PENDING: if (inject)         irq_state <= IDLE;
                default:                     irq_state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= 32'd0;
            FlushCount <= 32'd0;
            IrqCount   <= 16'd0;
        end else begin
            if (PCHold)      StallCount <= StallCount + 32'd1;
            if (IF_ID_Stall) FlushCount <= FlushCount + 32'd1;
            if (inject)      IrqCount   <= IrqCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the ROM returns the bitwise inverse of its address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        PCHold, IF_ID_Hold, IF_ID_Stall, IRQ;
    logic [31:0] BranchTarget, JrTarget;
    logic [25:0] JumpTarget;
    logic [31:0] InstAddr, Inst, ID_Inst, ID_PCPlus4;
    logic        ID_Valid, ID_Irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign Inst = ~InstAddr;

    fetch_stage dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCHold(PCHold),
        .IF_ID_Hold(IF_ID_Hold), .IF_ID_Stall(IF_ID_Stall),
        .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JrTarget(JrTarget),
        .IRQ(IRQ), .InstAddr(InstAddr), .Inst(Inst), .ID_Inst(ID_Inst),
        .ID_PCPlus4(ID_PCPlus4), .ID_Valid(ID_Valid), .ID_Irq(ID_Irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] inst, input logic [31:0] pc4,
                          input logic vld, input logic irq);
        chk({tag, ".inst"}, ID_Inst, inst);
        chk({tag, ".pc4"},  ID_PCPlus4, pc4);
        chk({tag, ".vld"},  {31'd0, ID_Valid}, {31'd0, vld});
        chk({tag, ".irq"},  {31'd0, ID_Irq}, {31'd0, irq});
    endtask

    initial begin
        reset = 1'b1; PCSrc = 3'd0; PCHold = 1'b0; IF_ID_Hold = 1'b0; IF_ID_Stall = 1'b0;
        IRQ = 1'b0; BranchTarget = 32'd0; JumpTarget = 26'd0; JrTarget = 32'd0;
        tick(); tick();
        chk("rst.pc", InstAddr, 32'h80000000);
        chk_id("rst", 32'h0, 32'h0, 1'b0, 1'b0);

        // sequential fetch out of reset
        reset = 1'b0;
        chk("seq0.pc", InstAddr, 32'h80000000);
        tick();
        chk("seq1.pc", InstAddr, 32'h80000004);
        chk_id("seq1", 32'h7FFFFFFF, 32'h80000004, 1'b1, 1'b0);
        tick();
        chk("seq2.pc", InstAddr, 32'h80000008);
        chk_id("seq2", 32'h7FFFFFFB, 32'h80000008, 1'b1, 1'b0);

        // JR out of kernel to 0x10
        PCSrc = 3'd3; JrTarget = 32'h00000010;
        tick();
        chk("jr10.pc", InstAddr, 32'h00000010);
        PCSrc = 3'd0;

        // load-use hold
        PCHold = 1'b1; IF_ID_Hold = 1'b1;
        tick();
        chk("hold.pc", InstAddr, 32'h00000010);
        chk_id("hold", 32'h7FFFFFF7, 32'h8000000C, 1'b1, 1'b0);
        PCHold = 1'b0; IF_ID_Hold = 1'b0;
        tick();
        chk("resume.pc", InstAddr, 32'h00000014);
        chk_id("resume", 32'hFFFFFFEF, 32'h00000014, 1'b1, 1'b0);
        tick();
        chk("seq18.pc", InstAddr, 32'h00000018);

        // taken branch with flush
        PCSrc = 3'd1; BranchTarget = 32'h00000100; IF_ID_Stall = 1'b1;
        tick();
        chk("br.pc", InstAddr, 32'h00000100);
        chk_id("br", 32'h0, 32'h0000001C, 1'b0, 1'b0);

        // stall and hold together: stall wins
        PCSrc = 3'd0; IF_ID_Hold = 1'b1;
        tick();
        chk("sh.pc", InstAddr, 32'h00000104);
        chk_id("sh", 32'h0, 32'h00000104, 1'b0, 1'b0);
        IF_ID_Stall = 1'b0; IF_ID_Hold = 1'b0;
        tick();
        chk("sh2.pc", InstAddr, 32'h00000108);
        chk_id("sh2", 32'hFFFFFEFB, 32'h00000108, 1'b1, 1'b0);

        // J: upper bits from PC[31] and ID_PCPlus4[30:28]
        PCSrc = 3'd2; JumpTarget = 26'h0000080;
        tick();
        chk("j.pc", InstAddr, 32'h00000200);

        // exception vector, then JR back to user mode
        PCSrc = 3'd4;
        tick();
        chk("illop.pc", InstAddr, 32'h80000004);
        PCSrc = 3'd5;
        tick();
        chk("xadr.pc", InstAddr, 32'h80000008);
        PCSrc = 3'd3; JrTarget = 32'h00000040;
        tick();
        chk("jr40.pc", InstAddr, 32'h00000040);
        PCSrc = 3'd0;
        tick();
        chk("jr40n.pc", InstAddr, 32'h00000044);
        chk("jr40n.pc4", ID_PCPlus4, 32'h00000044);

        // one-cycle IRQ pulse at PC=2C, bubble injected at PC=30
        PCSrc = 3'd3; JrTarget = 32'h0000002C;
        tick();
        PCSrc = 3'd0; IRQ = 1'b1;
        tick();
        chk("irq.lat.pc", InstAddr, 32'h00000030);
        chk_id("irq.lat", 32'hFFFFFFD3, 32'h00000030, 1'b1, 1'b0);
        IRQ = 1'b0;
        tick();
        chk("irq.inj.pc", InstAddr, 32'h00000034);
        chk_id("irq.inj", 32'h0, 32'h00000034, 1'b0, 1'b1);
        tick();
        chk_id("irq.post", 32'hFFFFFFCB, 32'h00000038, 1'b1, 1'b0);

        // latched in user mode, masked in kernel, deferred by redirect, not blocked by PCHold
        PCSrc = 3'd3; JrTarget = 32'h00000050;
        tick();
        IRQ = 1'b1; PCSrc = 3'd4;
        tick();
        IRQ = 1'b0; PCSrc = 3'd0;
        tick();
        chk("mask1.pc", InstAddr, 32'h80000008);
        chk_id("mask1", 32'h7FFFFFFB, 32'h80000008, 1'b1, 1'b0);
        tick();
        chk("mask2.irq", {31'd0, ID_Irq}, 32'd0);
        PCSrc = 3'd3; JrTarget = 32'h00000060;
        tick();
        chk("mask3.irq", {31'd0, ID_Irq}, 32'd0);
        PCSrc = 3'd1; BranchTarget = 32'h00000070;
        tick();
        chk("defer.pc", InstAddr, 32'h00000070);
        chk_id("defer", 32'hFFFFFF9F, 32'h00000064, 1'b1, 1'b0);
        PCSrc = 3'd0; PCHold = 1'b1;
        tick();
        chk("inj2.pc", InstAddr, 32'h00000070);
        chk_id("inj2", 32'h0, 32'h00000074, 1'b0, 1'b1);
        PCHold = 1'b0;
        tick();
        chk("inj2n.pc", InstAddr, 32'h00000074);
        chk_id("inj2n", 32'hFFFFFF8F, 32'h00000074, 1'b1, 1'b0);

        // low 31 bits wrap
        PCSrc = 3'd3; JrTarget = 32'h7FFFFFFC;
        tick();
        PCSrc = 3'd0;
        tick();
        chk("wrap.pc", InstAddr, 32'h00000000);
        chk("wrap.pc4", ID_PCPlus4, 32'h00000000);

        // reset mid-operation clears a pending interrupt
        IRQ = 1'b1;
        tick();
        IRQ = 1'b0; reset = 1'b1;
        tick();
        chk("rst2.pc", InstAddr, 32'h80000000);
        chk_id("rst2", 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0; PCSrc = 3'd3; JrTarget = 32'h00000020;
        tick();
        PCSrc = 3'd0;
        tick();
        chk("rst2n.pc", InstAddr, 32'h00000024);
        chk_id("rst2n", 32'hFFFFFFDF, 32'h00000024, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
